// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-VC FWFT flit FIFOs with round-robin crossbar and route-computation head selection.
module vc_input_buffer #(
  parameter int DATA_W = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH = 4,
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  output logic [NUM_VC-1:0] vc_status,
  output logic [NUM_VC-1:0] credit_out,
  input  logic [NUM_VC-1:0] vc_grant,
  output logic              cba_request,
  input  logic              cba_grant,
  output logic [DATA_W-1:0] cbs_data,
  output logic [VC_W-1:0]   cbs_vc,
  output logic              cbs_valid,
  output logic [DATA_W-1:0] rc_data,
  output logic [VC_W-1:0]   rc_vc,
  output logic              rc_valid,
  output logic [1:0]        err_flags
);
  localparam logic [VC_W:0] NV = (VC_W+1)'(NUM_VC);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
  logic [PTR_W-1:0] head [NUM_VC];
  logic [PTR_W-1:0] tail [NUM_VC];
  logic [PTR_W:0] count [NUM_VC];
  logic [VC_W-1:0] last_served, cbs_sel, rc_sel;
  logic [NUM_VC-1:0] full, nonempty, eligible, hit, enq, deq;
  logic illegal;

  // First requester found searching upward from last+1, wrapping; backward loop lets the nearest win.
  function automatic logic [VC_W-1:0] rr(input logic [NUM_VC-1:0] req, input logic [VC_W-1:0] last);
    rr = '0;
    for (int i = NUM_VC; i >= 1; i--)
      if (req[(int'(last) + i) % NUM_VC]) rr = VC_W'((int'(last) + i) % NUM_VC);
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      full[v] = count[v] == FULL;
      nonempty[v] = count[v] != '0;
      hit[v] = in_valid && in_vc == VC_W'(v);
      deq[v] = cba_grant && cbs_valid && cbs_sel == VC_W'(v);
    end
  end

  assign illegal = in_valid && ({1'b0, in_vc} >= NV);
  assign enq = hit & ~full;
  assign eligible = nonempty & vc_grant;
  assign vc_status = ~full;
  assign cbs_sel = rr(eligible, last_served);
  assign rc_sel = rr(nonempty, last_served);
  assign cbs_valid = |eligible;
  assign cba_request = cbs_valid;
  assign cbs_vc = cbs_valid ? cbs_sel : '0;
  assign cbs_data = cbs_valid ? mem[cbs_sel][head[cbs_sel]] : '0;
  assign rc_valid = |nonempty;
  assign rc_vc = rc_valid ? rc_sel : '0;
  assign rc_data = rc_valid ? mem[rc_sel][head[rc_sel]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head[v] <= '0;
        tail[v] <= '0;
        count[v] <= '0;
      end
      credit_out <= '0;
      err_flags <= '0;
      last_served <= VC_W'(NUM_VC - 1);
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (enq[v]) tail[v] <= tail[v] + 1'b1;
        if (deq[v]) head[v] <= head[v] + 1'b1;
        count[v] <= count[v] + (PTR_W+1)'(enq[v]) - (PTR_W+1)'(deq[v]);
      end
      credit_out <= deq;
      err_flags <= err_flags | {illegal, |(hit & full)};
      if (cbs_valid && cba_grant) last_served <= cbs_sel;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (enq[v]) mem[v][tail[v]] <= in_data;
  end
endmodule
